// File: rtl/sreg_ctrl_pkg.sv
// sreg_ctrl_pkg: shared types and constants for the Sreg sequencing controller.
//   state_t   - controller FSM states
//   MODE_SISO - serial-in/serial-out select value for choice
//   MODE_SIPO - serial-in/parallel-out select value for choice
package sreg_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_FLUSH,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   localparam logic MODE_SISO = 1'b0;
   localparam logic MODE_SIPO = 1'b1;

endpackage

// File: rtl/sreg_ctrl_cnt.sv
// sreg_ctrl_cnt: loadable up-counter with a terminal-count flag at WIDTH-1.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   load        - load load_val (has priority over en)
//   load_val    - value to load
//   en          - count up by one
//   cnt         - current count
//   tc          - high when cnt == WIDTH-1
module sreg_ctrl_cnt #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/sreg_ctrl.sv
// sreg_ctrl: sequences a WIDTH-bit word through an external Sreg shift register in SISO or
// SIPO mode and returns the recovered word over a valid/ready handshake.
// Ports:
//   clk, reset                  - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data   - request handshake; in_mode 0 = SISO, 1 = SIPO
//   sinp, choice                - serial data and mode select to Sreg
//   resetsi, resetpo            - active-high resets of the Sreg SISO / SIPO paths
//   sout, pout                  - Sreg serial and parallel outputs
//   out_valid/out_ready/out_data - response handshake
//   busy                        - high outside IDLE
//   mismatch                    - sticky compare error
// Optional feature: define SREG_CTRL_CHECK_EN to build the recovered-word compare that drives
// mismatch; otherwise mismatch is tied low.
module sreg_ctrl
   import sreg_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             sinp,
   output logic             choice,
   output logic             resetsi,
   output logic             resetpo,
   input  logic             sout,
   input  logic [WIDTH-1:0] pout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             mismatch
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   state_t           state;
   logic             mode;
   logic [WIDTH-1:0] sdat;     // shifts left during SHIFT; MSB drives sinp
   logic [WIDTH-2:0] col;      // serial bits collected so far in FLUSH
   logic [WIDTH-1:0] res;      // word recovered at the DONE-entry edge
   logic [CW-1:0]    cnt;
   logic             cnt_tc;
   logic             cnt_load;
   logic             cnt_en;
   logic             done_entry;

   // Counter restarts on accept and again when SHIFT hands over to FLUSH.
   assign cnt_load = ((state == ST_IDLE) && in_valid) || ((state == ST_SHIFT) && cnt_tc);
   assign cnt_en   = (state == ST_SHIFT) || (state == ST_FLUSH);

   sreg_ctrl_cnt #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val ('0),
      .en       (cnt_en),
      .cnt      (cnt),
      .tc       (cnt_tc)
   );

   // Final SISO bit arrives on sout during the last FLUSH cycle, so it is merged here.
   assign res        = (mode == MODE_SIPO) ? pout : {col, sout};
   assign done_entry = ((state == ST_FLUSH) && cnt_tc) || (state == ST_CAPTURE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         mode     <= MODE_SISO;
         sdat     <= '0;
         col      <= '0;
         out_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sdat  <= in_data;
                  mode  <= in_mode;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sdat <= {sdat[WIDTH-2:0], 1'b0};
               if (cnt_tc) begin
                  col   <= '0;
                  state <= (mode == MODE_SIPO) ? ST_CAPTURE : ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               col <= res[WIDTH-2:0];
               if (cnt_tc) begin
                  out_data <= res;
                  state    <= ST_DONE;
               end
            end
            ST_CAPTURE: begin
               out_data <= res;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SREG_CTRL_CHECK_EN
   logic [WIDTH-1:0] word;     // untouched copy of the accepted word for the compare
   logic             mismatch_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         word       <= '0;
         mismatch_q <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && in_valid) word <= in_data;
         if (done_entry && (res != word)) mismatch_q <= 1'b1;
      end
   end

   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

   // Control outputs decode from registered state only.
   always_comb begin
      in_ready  = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
      out_valid = (state == ST_DONE);
      sinp      = 1'b0;
      choice    = MODE_SISO;
      resetsi   = 1'b1;
      resetpo   = 1'b1;
      case (state)
         ST_SHIFT: begin
            sinp    = sdat[WIDTH-1];
            choice  = mode;
            resetsi = (mode == MODE_SIPO);
            resetpo = (mode == MODE_SISO);
         end
         ST_FLUSH: begin
            choice  = MODE_SISO;
            resetsi = 1'b0;
         end
         ST_CAPTURE: begin
            choice  = MODE_SIPO;
            resetpo = 1'b0;
         end
         default: ;
      endcase
   end

   logic unused_done_entry;
   assign unused_done_entry = done_entry;

endmodule

// File: tb/tb_sreg_ctrl.sv
// tb_sreg_ctrl: self-checking bench for sreg_ctrl with a behavioural Sreg attached.
// Expected behaviour comes from the cycle schedule of a word: SHIFT in cycles 1..W, then
// CAPTURE (SIPO) or FLUSH (SISO), out_valid from cycle W+2 (SIPO) or 2W+1 (SISO).
// Build with SREG_CTRL_CHECK_EN defined to also exercise the sticky mismatch flag.
module tb_sreg_ctrl;
   import sreg_ctrl_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_mode = 1'b0;
   logic         sinp, choice, resetsi, resetpo;
   logic         sout;
   logic [W-1:0] pout;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         busy;
   logic         mismatch;

   int vectors = 0;
   int errs    = 0;
   logic exp_mismatch = 1'b0;
   logic sout_stuck = 1'b0;

   // Behavioural Sreg: SISO and SIPO paths shift sinp in at the LSB end.
   logic [W-1:0] siso = '0;
   logic [W-1:0] sipo = '0;
   always @(posedge clk) begin
      if (resetsi) siso <= '0;
      else if (choice == MODE_SISO) siso <= {siso[W-2:0], sinp};
      if (resetpo) sipo <= '0;
      else if (choice == MODE_SIPO) sipo <= {sipo[W-2:0], sinp};
   end
   assign sout = sout_stuck ? 1'b0 : siso[W-1];
   assign pout = sipo;

   sreg_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .sinp      (sinp),
      .choice    (choice),
      .resetsi   (resetsi),
      .resetpo   (resetpo),
      .sout      (sout),
      .pout      (pout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_resetsi"}, resetsi, 1);
      chk({tag, "_resetpo"}, resetpo, 1);
      chk({tag, "_choice"}, choice, 0);
      chk({tag, "_sinp"}, sinp, 0);
   endtask

   // One complete word: accept, follow the schedule, hold DONE for stall extra cycles.
   task automatic run_word(input logic [W-1:0] d, input logic m, input int stall,
                           input logic [W-1:0] exp_out, input logic poke);
      int done_k;
      done_k = (m == MODE_SIPO) ? W + 2 : 2 * W + 1;
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      out_ready = 1'b0;
      chk("accept_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < done_k; k++) begin
         chk("run_busy", busy, 1);
         chk("run_in_ready", in_ready, 0);
         chk("run_out_valid", out_valid, 0);
         if (k <= W) begin
            chk("shift_sinp", sinp, d[W-k]);
            chk("shift_choice", choice, m);
            chk("shift_resetsi", resetsi, m);
            chk("shift_resetpo", resetpo, !m);
         end else if (m == MODE_SISO) begin
            chk("flush_sinp", sinp, 0);
            chk("flush_choice", choice, 0);
            chk("flush_resetsi", resetsi, 0);
            chk("flush_resetpo", resetpo, 1);
         end else begin
            chk("capture_choice", choice, 1);
            chk("capture_resetsi", resetsi, 1);
            chk("capture_resetpo", resetpo, 0);
         end
         tick();
      end
      for (int s = 0; s <= stall; s++) begin
         chk("done_out_valid", out_valid, 1);
         chk("done_out_data", out_data, exp_out);
         chk("done_in_ready", in_ready, 0);
         chk("done_busy", busy, 1);
         chk("done_resetsi", resetsi, 1);
         chk("done_resetpo", resetpo, 1);
         chk("done_mismatch", mismatch, exp_mismatch);
         if (poke) begin
            in_valid = 1'b1;
            in_data  = ~d;
            in_mode  = ~m;
         end
         if (s == stall) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         tick();
      end
      out_ready = 1'b0;
      chk_idle("post");
   endtask

   initial begin
      logic [W-1:0] rd;
      logic         rm;
      // Reset values are held while reset is high.
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("reset");
         chk("reset_out_data", out_data, 0);
         chk("reset_mismatch", mismatch, 0);
      end
      reset = 1'b0;
      tick();
      chk_idle("idle");

      // Directed words from the plan, then backpressure with ignored in_valid.
      run_word(4'b1011, MODE_SIPO, 0, 4'b1011, 1'b0);
      run_word(4'b1011, MODE_SISO, 0, 4'b1011, 1'b0);
      run_word(4'b0110, MODE_SISO, 5, 4'b0110, 1'b1);
      run_word(4'b1001, MODE_SIPO, 5, 4'b1001, 1'b1);

      // Back-to-back SIPO words: one IDLE cycle in between, checked inside run_word.
      run_word(4'b0001, MODE_SIPO, 0, 4'b0001, 1'b0);
      run_word(4'b1000, MODE_SIPO, 0, 4'b1000, 1'b0);

      // Reset in cycle 3 of a SIPO shift discards the word.
      in_data  = 4'b1101;
      in_mode  = MODE_SIPO;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("pre_reset_busy", busy, 1);
      reset = 1'b1;
      tick();
      chk_idle("midreset");
      chk("midreset_out_data", out_data, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 2 * W + 2; i++) begin
         tick();
         chk("after_reset_no_out_valid", out_valid, 0);
         chk("after_reset_busy", busy, 0);
      end
      out_ready = 1'b0;

`ifdef SREG_CTRL_CHECK_EN
      // Stuck sout loses the SISO word; mismatch sticks until reset.
      sout_stuck = 1'b1;
      exp_mismatch = 1'b1;
      run_word(4'b0110, MODE_SISO, 0, 4'b0000, 1'b0);
      sout_stuck = 1'b0;
      run_word(4'b0011, MODE_SIPO, 0, 4'b0011, 1'b0);
      chk("sticky_mismatch", mismatch, 1);
      reset = 1'b1;
      tick();
      chk("cleared_mismatch", mismatch, 0);
      reset = 1'b0;
      exp_mismatch = 1'b0;
      tick();
`endif

      // Random words, modes and stall lengths against the schedule model.
      for (int n = 0; n < 24; n++) begin
         rd = W'($urandom_range(0, (1 << W) - 1));
         rm = 1'($urandom_range(0, 1));
         run_word(rd, rm, int'($urandom_range(0, 3)), rd, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
